// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------------------------
// imem_boot_loader
//
// Boot/program-load controller between a host word stream and the PikaRISC instruction memory
// write port. It holds the core in reset, optionally zero-fills the whole instruction memory,
// writes a program of load_len words at word addresses 0..load_len-1, waits RESET_HOLD cycles
// after the final write and then releases the core's reset.
//
// Parameters:
//   ADDR_WIDTH  instruction memory word-address width
//   DEPTH       number of instruction words (must equal 2**ADDR_WIDTH)
//   CLEAR_EN    1: zero-fill all DEPTH words before loading, 0: go straight to loading
//   RESET_HOLD  cycles cpu_reset stays high after the last program write (>= 1)
//
// Ports:
//   clk_i             system clock, rising edge
//   reset_i           asynchronous active-high reset, returns everything to IDLE
//   start_i           begin a load (sampled only in IDLE or RUN)
//   load_len_i        program length in words, sampled with start_i
//   in_valid_i        host word valid
//   in_data_i         host instruction word
//   in_ready_o        loader accepts a word this cycle (decoded from state, high only in LOAD)
//   imem_wr_en_o      instruction memory write strobe (registered)
//   imem_wr_addr_o    word index, zero-extended (registered)
//   imem_wr_data_o    write data (registered)
//   cpu_reset_o       active-high reset to the core (registered)
//   busy_o            high in CLEAR, LOAD and RELEASE (registered)
//   done_o            high in RUN (registered)
//   error_o           sticky illegal-length flag, cleared by the next legal start (registered)
//   words_loaded_o    words accepted in the current load (registered)
// ---------------------------------------------------------------------------------------------
module imem_boot_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 256,
  parameter bit          CLEAR_EN   = 1'b1,
  parameter int unsigned RESET_HOLD = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH:0]   load_len_i,
  input  logic                  in_valid_i,
  input  logic [31:0]           in_data_i,
  output logic                  in_ready_o,
  output logic                  imem_wr_en_o,
  output logic [31:0]           imem_wr_addr_o,
  output logic [31:0]           imem_wr_data_o,
  output logic                  cpu_reset_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [ADDR_WIDTH:0]   words_loaded_o
);

  localparam int unsigned CntW  = ADDR_WIDTH + 1;
  localparam int unsigned HoldW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  localparam logic [CntW-1:0]       DepthLen = CntW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] AddrMax  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [HoldW-1:0]      HoldMax  = HoldW'(RESET_HOLD - 1);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StLoad,
    StRelease,
    StRun
  } state_e;

  // Control state
  state_e                state_q, state_d;
  logic [CntW-1:0]       len_q, len_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [HoldW-1:0]      hold_cnt_q, hold_cnt_d;
  logic [CntW-1:0]       words_q, words_d;
  logic                  error_q, error_d;

  // Registered outputs
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic            len_legal;
  logic            accept;
  logic [CntW-1:0] words_inc;

  assign len_legal = (load_len_i != '0) && (load_len_i <= DepthLen);
  assign accept    = in_valid_i && (state_q == StLoad);
  assign words_inc = words_q + CntW'(1);

  // -------------------------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      len_q       <= '0;
      clr_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      words_q     <= '0;
      error_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      clr_cnt_q   <= clr_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      words_q     <= words_d;
      error_q     <= error_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // -------------------------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    clr_cnt_d  = clr_cnt_q;
    hold_cnt_d = hold_cnt_q;
    words_d    = words_q;
    error_d    = error_q;

    unique case (state_q)
      // start is only honoured while the core is parked or running; a restart from RUN
      // behaves exactly like a fresh start from IDLE.
      StIdle, StRun: begin
        if (start_i) begin
          if (len_legal) begin
            len_d     = load_len_i;
            error_d   = 1'b0;
            words_d   = '0;
            clr_cnt_d = '0;
            state_d   = CLEAR_EN ? StClear : StLoad;
          end else begin
            error_d = 1'b1;
          end
        end
      end

      // clr_cnt_q is the address being written in the current cycle.
      StClear: begin
        if (clr_cnt_q == AddrMax) begin
          state_d = StLoad;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        end
      end

      // Leaving LOAD on the last accept drops in_ready for the following cycle, so the host
      // can never push one word too many.
      StLoad: begin
        if (accept) begin
          words_d = words_inc;
          if (words_inc == len_q) begin
            state_d    = StRelease;
            hold_cnt_d = '0;
          end
        end
      end

      // RELEASE is entered on the final accept edge, so RESET_HOLD cycles spent here place
      // the falling edge of cpu_reset exactly RESET_HOLD edges after that accept.
      StRelease: begin
        if (hold_cnt_q == HoldMax) begin
          state_d = StRun;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // -------------------------------------------------------------------------------------------
  // Output logic: every output except in_ready is registered, so the values are derived from
  // the next state and land in the same cycle as the state they describe.
  // -------------------------------------------------------------------------------------------
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (state_d == StClear) begin
      wr_en_d   = 1'b1;
      wr_addr_d = clr_cnt_d;
      wr_data_d = '0;
    end else if (accept) begin
      // words_q never exceeds DEPTH-1 at an accept, so the low bits are the full address.
      wr_en_d   = 1'b1;
      wr_addr_d = words_q[ADDR_WIDTH-1:0];
      wr_data_d = in_data_i;
    end

    cpu_reset_d = (state_d != StRun);
    done_d      = (state_d == StRun);
    busy_d      = (state_d == StClear) || (state_d == StLoad) || (state_d == StRelease);
  end

  assign in_ready_o     = (state_q == StLoad);
  assign imem_wr_en_o   = wr_en_q;
  assign imem_wr_addr_o = 32'(wr_addr_q);
  assign imem_wr_data_o = wr_data_q;
  assign cpu_reset_o    = cpu_reset_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign words_loaded_o = words_q;

endmodule
